// File: rtl/cpu_trace_uart.sv
// cpu_trace_uart: queues CPU state snapshots on change and streams them as 6-byte 8N1 UART frames.
module cpu_trace_uart #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_en,
    input  logic [7:0]               ra,
    input  logic [7:0]               rb,
    input  logic [7:0]               rc,
    input  logic [7:0]               rd,
    input  logic                     zf,
    input  logic                     sf,
    input  logic [7:0]               db,
    output logic                     tx,
    output logic                     busy,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_n;
    logic [41:0] mem [DEPTH];
    logic [41:0] snap, prev, frame, frame_n;
    logic prev_valid, push, pop, full, accept, drop, cnt_last;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] bit_idx, bit_n, byte_idx, byte_n;
    logic [7:0] cur;

    assign snap     = {zf, sf, ra, rb, rc, rd, db};
    assign push     = trace_en && (!prev_valid || snap != prev);
    assign full     = fifo_level == LW'(DEPTH);
    assign accept   = push && (!full || pop);
    assign drop     = push && full && !pop;
    assign cnt_last = cnt == CW'(CLKS_PER_BIT - 1);
    assign cur      = byte_idx == 3'd0 ? {6'b101000, frame[40], frame[41]} :
                      byte_idx == 3'd1 ? frame[39:32] :
                      byte_idx == 3'd2 ? frame[31:24] :
                      byte_idx == 3'd3 ? frame[23:16] :
                      byte_idx == 3'd4 ? frame[15:8]  : frame[7:0];
    assign busy     = state != IDLE;
    assign tx       = state == START ? 1'b0 : state == DATA ? cur[bit_idx] : 1'b1;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        byte_n  = byte_idx;
        frame_n = frame;
        pop     = 1'b0;
        case (state)
            IDLE: if (fifo_level != '0) begin
                pop     = 1'b1;
                frame_n = mem[rd_ptr];
                byte_n  = 3'd0;
                cnt_n   = '0;
                state_n = START;
            end
            START: begin
                cnt_n = cnt_last ? '0 : cnt + CW'(1);
                bit_n = cnt_last ? 3'd0 : bit_idx;
                state_n = cnt_last ? DATA : START;
            end
            DATA: begin
                cnt_n = cnt_last ? '0 : cnt + CW'(1);
                bit_n = cnt_last && bit_idx != 3'd7 ? bit_idx + 3'd1 : bit_idx;
                state_n = cnt_last && bit_idx == 3'd7 ? STOP : DATA;
            end
            STOP: begin
                cnt_n = cnt_last ? '0 : cnt + CW'(1);
                byte_n = cnt_last && byte_idx < 3'd5 ? byte_idx + 3'd1 : byte_idx;
                state_n = !cnt_last ? STOP : byte_idx < 3'd5 ? START : IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            frame    <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            byte_idx <= byte_n;
            frame    <= frame_n;
        end
    end

    always_ff @(posedge clk)
        if (accept) mem[wr_ptr] <= snap;

    // prev follows every enabled sample, so a dropped snapshot is never re-queued later
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (trace_en) begin
                prev       <= snap;
                prev_valid <= 1'b1;
            end
            wr_ptr     <= wr_ptr + AW'(accept);
            rd_ptr     <= rd_ptr + AW'(pop);
            fifo_level <= fifo_level + LW'(accept) - LW'(pop);
            if (drop) overflow <= 1'b1;
            if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end
endmodule
